multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Parametrised successor to the single-cycle opcode decoder: a Moore FSM control unit for the multi-cycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps, one state per clock.
- Holds in memory states until the memory handshake completes.
- Adds BNE and an illegal-opcode trap; the single-cycle decoder had neither.
- Sits between the instruction register's opcode field and all datapath enables and mux selects.

Parameters:
- OPW, 8, opcode input width; compare uses all OPW bits.
- OP_RTYPE, 1, R-format opcode.
- OP_LW, 2, load word opcode.
- OP_SW, 3, store word opcode.
- OP_J, 4, jump opcode.
- OP_BEQ, 5, branch-if-equal opcode.
- OP_BNE, 6, branch-if-not-equal opcode.
- OP_ADDI, 7, add-immediate opcode.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in  input  OPW  opcode field from the instruction register.
- mem_ready  input  1  memory access completes this cycle.
- pcwrite  output  1  unconditional PC load.
- pcwritecond  output  1  PC load qualified by ALU zero.
- branch_ne  output  1  1 = take the branch on !zero (BNE); 0 = on zero.
- iord  output  1  memory address mux: 0 = PC, 1 = ALUOut.
- memread  output  1  memory read strobe.
- memwrite  output  1  memory write strobe.
- irwrite  output  1  instruction register load.
- memtoreg  output  1  register write-data mux: 1 = MDR.
- regdest  output  1  destination register: 1 = rd, 0 = rt.
- regwrite  output  1  register file write.
- alusrca  output  1  ALU A mux: 0 = PC, 1 = rs.
- alusrcb  output  2  ALU B mux: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- aluop  output  2  ALU op class: 00 = add, 01 = sub, 10 = funct.
- pcsource  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- illegal  output  1  one-cycle pulse on an undecoded opcode.
- state_o  output  4  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Reset: state = FETCH at the next edge; takes priority over any transition, including mid-instruction or mid-memory-wait.
- Every output not listed for a state is 0.
- Reset-cycle outputs are the FETCH values: memread=1, alusrcb=01, all else 0 (and pcwrite/irwrite 0 while mem_ready=0).
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - irwrite = pcwrite = mem_ready; these are the only mem_ready-qualified outputs.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by opcode:
  - RTYPE -> EXEC; LW or SW -> MEMADR; BEQ or BNE -> BRANCH; J -> JUMP; ADDI -> ADDIEX.
  - Any other opcode -> FETCH with illegal=1 for this cycle. No register or memory write.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. LW -> MEMRD; SW -> MEMWR.
- MEMRD: memread=1, iord=1. Waits for mem_ready, then -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdest=0. -> FETCH.
- MEMWR: memwrite=1, iord=1. Holds while mem_ready=0; -> FETCH when mem_ready=1.
- EXEC: alusrca=1, alusrcb=00, aluop=10. -> RWB.
- RWB: regwrite=1, regdest=1, memtoreg=0. -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01.
  - branch_ne = 1 if the opcode is BNE, 0 if BEQ.
  - -> FETCH.
- JUMP: pcwrite=1, pcsource=10. -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. -> ADDIWB.
- ADDIWB: regwrite=1, regdest=0, memtoreg=0. -> FETCH.
- Opcode stability: `in` is sampled combinationally in DECODE, MEMADR and BRANCH. The IR is stable there because irwrite is 0 outside FETCH.
- Latencies with mem_ready held at 1: R, ADDI, SW = 4 cycles; LW = 5 cycles; BEQ, BNE, J = 3 cycles.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Unused state encodings (12-15) -> FETCH on the next edge; illegal=0.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_PERF_EN.
- Defined: adds output ports cyc_cnt (32 bits) and instr_cnt (32 bits).
  - cyc_cnt increments every non-reset cycle.
  - instr_cnt increments on every transition into FETCH from a non-FETCH state, including illegal traps.
  - Both clear to 0 on reset and wrap modulo 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-MEMRD with mem_ready=0 -> state_o=0 next cycle; memread=1, alusrcb=01, pcwrite=0, irwrite=0.
- in=1 (RTYPE), mem_ready=1 -> state sequence 0,1,6,7,0; RWB cycle shows regwrite=1, regdest=1; 4 cycles total.
- in=2 (LW), mem_ready low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0; memread=iord=1 throughout MEMRD; MEMWB shows memtoreg=1, regwrite=1.
- in=6 (BNE) -> BRANCH shows pcwritecond=1, branch_ne=1, aluop=01, pcsource=01. Repeat with in=5 (BEQ) -> branch_ne=0.
- in=8'hFF in DECODE -> illegal=1 for exactly one cycle; next state FETCH; no regwrite, memwrite or pcwrite observed.
- With MULTICYCLE_CONTROL_PERF_EN defined: run J then ADDI from reset with mem_ready=1 -> instr_cnt=2, cyc_cnt=7.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore FSM control unit for the multi-cycle MIPS datapath (fetch/decode/execute/mem/writeback).
// Optional perf counters cyc_cnt/instr_cnt are enabled with `define MULTICYCLE_CONTROL_PERF_EN.
module multicycle_control #(
   parameter int             OPW      = 8,
   parameter logic [OPW-1:0] OP_RTYPE = OPW'(1),
   parameter logic [OPW-1:0] OP_LW    = OPW'(2),
   parameter logic [OPW-1:0] OP_SW    = OPW'(3),
   parameter logic [OPW-1:0] OP_J     = OPW'(4),
   parameter logic [OPW-1:0] OP_BEQ   = OPW'(5),
   parameter logic [OPW-1:0] OP_BNE   = OPW'(6),
   parameter logic [OPW-1:0] OP_ADDI  = OPW'(7)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] in,
   input  logic           mem_ready,
   output logic           pcwrite,
   output logic           pcwritecond,
   output logic           branch_ne,
   output logic           iord,
   output logic           memread,
   output logic           memwrite,
   output logic           irwrite,
   output logic           memtoreg,
   output logic           regdest,
   output logic           regwrite,
   output logic           alusrca,
   output logic [1:0]     alusrcb,
   output logic [1:0]     aluop,
   output logic [1:0]     pcsource,
   output logic           illegal,
   output logic [3:0]     state_o
`ifdef MULTICYCLE_CONTROL_PERF_EN
   ,
   output logic [31:0]    cyc_cnt,
   output logic [31:0]    instr_cnt
`endif
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
      MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
      BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11
   } state_t;

   state_t state, next;

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= next;
   end

   assign state_o = state;

   always_comb begin
      next        = FETCH;
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      branch_ne   = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdest     = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      aluop       = 2'b00;
      pcsource    = 2'b00;
      illegal     = 1'b0;
      // While reset is held the datapath sees a quiescent FETCH, whatever state we were in.
      if (reset) begin
         memread = 1'b1;
         alusrcb = 2'b01;
      end else begin
         case (state)
            FETCH: begin
               memread = 1'b1;
               alusrcb = 2'b01;
               irwrite = mem_ready;
               pcwrite = mem_ready;
               next    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
               alusrcb = 2'b11;
               if (in == OP_RTYPE)                  next = EXEC;
               else if (in == OP_LW || in == OP_SW)   next = MEMADR;
               else if (in == OP_BEQ || in == OP_BNE) next = BRANCH;
               else if (in == OP_J)                 next = JUMP;
               else if (in == OP_ADDI)              next = ADDIEX;
               else begin
                  next    = FETCH;
                  illegal = 1'b1;
               end
            end
            MEMADR: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
               if (in == OP_LW)      next = MEMRD;
               else if (in == OP_SW) next = MEMWR;
               else                  next = FETCH;
            end
            MEMRD: begin
               memread = 1'b1;
               iord    = 1'b1;
               next    = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
               regwrite = 1'b1;
               memtoreg = 1'b1;
            end
            MEMWR: begin
               memwrite = 1'b1;
               iord     = 1'b1;
               next     = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
               alusrca = 1'b1;
               aluop   = 2'b10;
               next    = RWB;
            end
            RWB: begin
               regwrite = 1'b1;
               regdest  = 1'b1;
            end
            BRANCH: begin
               alusrca     = 1'b1;
               aluop       = 2'b01;
               pcwritecond = 1'b1;
               pcsource    = 2'b01;
               branch_ne   = (in == OP_BNE);
            end
            JUMP: begin
               pcwrite  = 1'b1;
               pcsource = 2'b10;
            end
            ADDIEX: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
               next    = ADDIWB;
            end
            ADDIWB: regwrite = 1'b1;
            default: next = FETCH;
         endcase
      end
   end

`ifdef MULTICYCLE_CONTROL_PERF_EN
   // An instruction retires (or traps) whenever we re-enter FETCH from elsewhere.
   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_cnt   <= '0;
         instr_cnt <= '0;
      end else begin
         cyc_cnt <= cyc_cnt + 32'd1;
         if (state != FETCH && next == FETCH) instr_cnt <= instr_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control: per-opcode state paths plus a control-word table.
module tb_multicycle_control;
   logic       clk = 1'b0;
   logic       reset;
   logic       mem_ready;
   logic [7:0] in;
   logic       pcwrite, pcwritecond, branch_ne, iord, memread, memwrite, irwrite;
   logic       memtoreg, regdest, regwrite, alusrca, illegal;
   logic [1:0] alusrcb, aluop, pcsource;
   logic [3:0] state_o;
`ifdef MULTICYCLE_CONTROL_PERF_EN
   logic [31:0] cyc_cnt, instr_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   int path[8];
   int plen;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .reset(reset), .in(in), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .pcwritecond(pcwritecond), .branch_ne(branch_ne), .iord(iord),
      .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg),
      .regdest(regdest), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
      .aluop(aluop), .pcsource(pcsource), .illegal(illegal), .state_o(state_o)
`ifdef MULTICYCLE_CONTROL_PERF_EN
      , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
   );

   logic [17:0] word;
   assign word = {pcwrite, pcwritecond, branch_ne, iord, memread, memwrite, irwrite,
                  memtoreg, regdest, regwrite, alusrca, alusrcb, aluop, pcsource, illegal};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected control word for a state, from the per-state output table.
   function automatic logic [17:0] exp_word(input int st, input logic mr, input logic [7:0] op);
      logic pw = 0, pwc = 0, bne = 0, io = 0, mrd = 0, mwr = 0, irw = 0;
      logic m2r = 0, rd = 0, rw = 0, sa = 0, ill = 0;
      logic [1:0] sb = 0, ao = 0, ps = 0;
      case (st)
         0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
         1:  begin sb = 2'b11; ill = !(op >= 8'd1 && op <= 8'd7); end
         2:  begin sa = 1; sb = 2'b10; end
         3:  begin mrd = 1; io = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; io = 1; end
         6:  begin sa = 1; ao = 2'b10; end
         7:  begin rw = 1; rd = 1; end
         8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; bne = (op == 8'd6); end
         9:  begin pw = 1; ps = 2'b10; end
         10: begin sa = 1; sb = 2'b10; end
         11: rw = 1;
         default: ;
      endcase
      return {pw, pwc, bne, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, ao, ps, ill};
   endfunction

   function automatic int base_lat(input logic [7:0] op);
      case (op)
         8'd1, 8'd3, 8'd7: return 4;
         8'd2:             return 5;
         8'd4, 8'd5, 8'd6: return 3;
         default:          return 2;
      endcase
   endfunction

   task automatic set_path(input logic [7:0] op);
      path[0] = 0; path[1] = 1; plen = 2;
      case (op)
         8'd1: begin path[2] = 6;  path[3] = 7;  plen = 4; end
         8'd2: begin path[2] = 2;  path[3] = 3;  path[4] = 4; plen = 5; end
         8'd3: begin path[2] = 2;  path[3] = 5;  plen = 4; end
         8'd4: begin path[2] = 9;  plen = 3; end
         8'd5, 8'd6: begin path[2] = 8; plen = 3; end
         8'd7: begin path[2] = 10; path[3] = 11; plen = 4; end
         default: ;
      endcase
   endtask

   // Entered and left at a falling edge: drive, check combinational outputs, wait one cycle.
   task automatic step(input logic mr, input int st, input logic [7:0] op, input string tag);
      mem_ready = mr;
      in        = op;
      #1;
      chk({tag, "_state"}, 32'(state_o), 32'(st));
      chk({tag, "_ctl"}, 32'(word), 32'(exp_word(st, mr, op)));
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      mem_ready = 1'b0;
      #1;
      chk("rst_ctl", 32'(word), 32'(exp_word(0, 1'b0, 8'd0)));
      @(negedge clk);
      reset = 1'b0;
   endtask

   // mode 0: mem_ready always 1; 1: random; 2: two stall cycles in MEMRD
   task automatic run_instr(input logic [7:0] op, input int mode);
      int   idx = 0, cyc = 0, stalls = 0, w3 = 0, st;
      logic mr;
      set_path(op);
      while (idx < plen && cyc < 200) begin
         st = path[idx];
         case (mode)
            0:       mr = 1'b1;
            1:       mr = ($urandom_range(0, 3) != 0);
            default: mr = !(st == 3 && w3 < 2);
         endcase
         if (mode == 2 && st == 3 && !mr) w3++;
         step(mr, st, op, $sformatf("op%0h", op));
         cyc++;
         if ((st == 0 || st == 3 || st == 5) && !mr) stalls++;
         else idx++;
      end
      chk($sformatf("lat_op%0h", op), 32'(cyc), 32'(base_lat(op) + stalls));
   endtask

   initial begin
      logic [7:0] op;
      reset = 1'b1; mem_ready = 1'b0; in = 8'd0;
      @(negedge clk);
      do_reset();

      // reset while stalled in MEMRD
      step(1'b1, 0, 8'd2, "lw_pre");
      step(1'b1, 1, 8'd2, "lw_pre");
      step(1'b1, 2, 8'd2, "lw_pre");
      step(1'b0, 3, 8'd2, "lw_pre");
      do_reset();
      step(1'b0, 0, 8'd2, "post_rst");

      run_instr(8'd1, 0);
      run_instr(8'd2, 2);
      run_instr(8'd3, 0);
      run_instr(8'd6, 0);
      run_instr(8'd5, 0);
      run_instr(8'hFF, 0);
      run_instr(8'd0, 0);

      do_reset();
      run_instr(8'd4, 0);
      run_instr(8'd7, 0);
`ifdef MULTICYCLE_CONTROL_PERF_EN
      #1;
      chk("instr_cnt", instr_cnt, 32'd2);
      chk("cyc_cnt", cyc_cnt, 32'd7);
`endif

      for (int n = 0; n < 250; n++) begin
         int r = $urandom_range(0, 9);
         op = (r < 8) ? 8'(r) : 8'($urandom_range(8, 255));
         run_instr(op, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout reached without finishing");
      $fatal(1);
   end
endmodule
